// File: rtl/spi_burst_ram_if.sv
// ---------------------------------------------------------------------------------------------
// spi_burst_ram_if
//
// Word-level link between an SPI slave shift engine and the command RAM behind it.
//
// Signals:
//   rx_valid  qualifies din; one command word per cycle while high
//   din       [DATA_W+1:DATA_W] = command, [DATA_W-1:0] = payload
//   dout      read data returned to the SPI slave
//   tx_valid  one-cycle pulse, dout carries a fresh read result
//   err       sticky out-of-range flag
//
// Modports:
//   master  SPI-slave side: drives commands, consumes read data
//   slave   RAM side: consumes commands, drives read data and err
// ---------------------------------------------------------------------------------------------
interface spi_burst_ram_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic              rx_valid;
    logic [DATA_W+1:0] din;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              err;

    modport master (
        output rx_valid,
        output din,
        input  dout,
        input  tx_valid,
        input  err
    );

    modport slave (
        input  rx_valid,
        input  din,
        output dout,
        output tx_valid,
        output err
    );

endinterface

// File: rtl/spi_burst_ram.sv
// ---------------------------------------------------------------------------------------------
// spi_burst_ram
//
// SPI-slave-side command RAM with configurable width/depth, address auto-increment bursts,
// selectable read latency and a sticky out-of-range error flag.
//
// Commands (din[DATA_W+1:DATA_W]):
//   00  set write address from payload[ADDR_W-1:0]
//   01  write payload at the write address (post-increments when AUTO_INC)
//   10  set read address from payload[ADDR_W-1:0]
//   11  read the word at the read address (post-increments when AUTO_INC)
//
// Ports:
//   clk    clock, everything on the rising edge
//   rst_n  synchronous active-low reset; clears address registers, outputs, err and the read
//          pipeline. Memory contents are kept.
//   bus    spi_burst_ram_if slave modport (rx_valid/din in, dout/tx_valid/err out)
//
// Parameters:
//   DATA_W     payload and memory word width; must match the interface DATA_W
//   ADDR_W     address register width (ADDR_W <= DATA_W, MEM_DEPTH <= 2**ADDR_W)
//   MEM_DEPTH  number of words
//   AUTO_INC   1 = addresses post-increment after each write/read, wrapping to 0
//   READ_LAT   1 or 2 edges from an accepted read to tx_valid
// ---------------------------------------------------------------------------------------------
module spi_burst_ram #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256,
    parameter bit          AUTO_INC  = 1'b1,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_burst_ram_if.slave bus
);

    typedef enum logic [1:0] {
        CmdSetWr = 2'b00,
        CmdWrite = 2'b01,
        CmdSetRd = 2'b10,
        CmdRead  = 2'b11
    } cmd_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_DEPTH - 1);
    // Index width of the storage array; in-range addresses always fit in this many bits.
    localparam int unsigned MemIdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // ---------------------------------------------------------------------------------------
    // Command decode
    // ---------------------------------------------------------------------------------------
    cmd_e              cmd;
    logic [DATA_W-1:0] payload;

    assign cmd     = cmd_e'(bus.din[DATA_W+1:DATA_W]);
    assign payload = bus.din[DATA_W-1:0];

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              tx_valid_q, tx_valid_d;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              mem_we;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_data;

    // Result presented to the output register after READ_LAT-1 extra stages.
    logic              out_fire;
    logic [DATA_W-1:0] out_data;

    // Zero-extend to 32 bits so MEM_DEPTH == 2**ADDR_W compares correctly.
    assign wr_in_range = (32'(wr_addr_q) < MEM_DEPTH);
    assign rd_in_range = (32'(rd_addr_q) < MEM_DEPTH);

    // Post-increment with wrap; an out-of-range address also wraps to 0.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic              in_range);
        if (!AUTO_INC) begin
            return addr;
        end
        if (!in_range || (addr == LastAddr)) begin
            return '0;
        end
        return addr + ADDR_W'(1);
    endfunction

    // ---------------------------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------------------------
    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        rd_fire   = 1'b0;

        if (bus.rx_valid) begin
            unique case (cmd)
                CmdSetWr: begin
                    wr_addr_d = payload[ADDR_W-1:0];
                end
                CmdWrite: begin
                    mem_we    = wr_in_range;
                    err_d     = err_q | ~wr_in_range;
                    wr_addr_d = next_addr(wr_addr_q, wr_in_range);
                end
                CmdSetRd: begin
                    rd_addr_d = payload[ADDR_W-1:0];
                end
                CmdRead: begin
                    rd_fire   = 1'b1;
                    err_d     = err_q | ~rd_in_range;
                    rd_addr_d = next_addr(rd_addr_q, rd_in_range);
                end
            endcase
        end
    end

    // Asynchronous array read; a write committed at the previous edge is already visible.
    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = mem_q[rd_addr_q[MemIdxW-1:0]];
        end
    end

    // ---------------------------------------------------------------------------------------
    // Read pipeline
    // ---------------------------------------------------------------------------------------
    if (READ_LAT == 2) begin : gen_lat2
        logic              pipe_valid_q, pipe_valid_d;
        logic [DATA_W-1:0] pipe_data_q, pipe_data_d;

        always_comb begin
            pipe_valid_d = rd_fire;
            pipe_data_d  = rd_fire ? rd_data : pipe_data_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pipe_valid_q <= 1'b0;
                pipe_data_q  <= '0;
            end else begin
                pipe_valid_q <= pipe_valid_d;
                pipe_data_q  <= pipe_data_d;
            end
        end

        assign out_fire = pipe_valid_q;
        assign out_data = pipe_data_q;
    end else begin : gen_lat1
        assign out_fire = rd_fire;
        assign out_data = rd_data;
    end

    // dout holds the last completed read; tx_valid pulses once per completed read.
    always_comb begin
        tx_valid_d = out_fire;
        dout_d     = out_fire ? out_data : dout_q;
    end

    // ---------------------------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            err_q      <= 1'b0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Storage has no reset; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[wr_addr_q[MemIdxW-1:0]] <= payload;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_spi_burst_ram.sv
// Three builds share one command stream:
//   a: READ_LAT=1, MEM_DEPTH=256   b: READ_LAT=2, MEM_DEPTH=256   c: READ_LAT=1, MEM_DEPTH=200
// Inputs are driven and outputs sampled on the falling edge.
module tb_spi_burst_ram;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [9:0] din;

    int n_cmp;
    int n_err;

    spi_burst_ram_if #(.DATA_W(8)) bus_a ();
    spi_burst_ram_if #(.DATA_W(8)) bus_b ();
    spi_burst_ram_if #(.DATA_W(8)) bus_c ();

    assign bus_a.rx_valid = rx_valid;
    assign bus_a.din      = din;
    assign bus_b.rx_valid = rx_valid;
    assign bus_b.din      = din;
    assign bus_c.rx_valid = rx_valid;
    assign bus_c.din      = din;

    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b1), .READ_LAT(1)) u_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b1), .READ_LAT(2)) u_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1'b1), .READ_LAT(1)) u_c (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One command, accepted at the next rising edge; returns on the following falling edge.
    task automatic send(input logic [1:0] c, input logic [7:0] p);
        rx_valid = 1'b1;
        din      = {c, p};
        @(negedge clk);
        rx_valid = 1'b0;
        din      = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = '0;
        idle(3);
        n_cmp++;
        if ({bus_a.tx_valid, bus_a.err, bus_a.dout} !== 10'h000) begin
            n_err++;
            $display("FAIL reset_a: got %b/%b/%h want 0/0/00", bus_a.tx_valid, bus_a.err, bus_a.dout);
        end
        n_cmp++;
        if ({bus_b.tx_valid, bus_b.err, bus_b.dout} !== 10'h000) begin
            n_err++;
            $display("FAIL reset_b: got %b/%b/%h want 0/0/00", bus_b.tx_valid, bus_b.err, bus_b.dout);
        end
        n_cmp++;
        if ({bus_c.tx_valid, bus_c.err, bus_c.dout} !== 10'h000) begin
            n_err++;
            $display("FAIL reset_c: got %b/%b/%h want 0/0/00", bus_c.tx_valid, bus_c.err, bus_c.dout);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic;
        send(2'b00, 8'h10);
        send(2'b01, 8'hA5);
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        n_cmp++;
        if ({bus_a.tx_valid, bus_a.err, bus_a.dout} !== {1'b1, 1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL basic_a: got tx=%b err=%b dout=%h want 1/0/a5",
                     bus_a.tx_valid, bus_a.err, bus_a.dout);
        end
        n_cmp++;
        if (bus_b.tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_b_early: got tx=%b want 0", bus_b.tx_valid);
        end
        n_cmp++;
        if ({bus_c.tx_valid, bus_c.dout} !== {1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL basic_c: got tx=%b dout=%h want 1/a5", bus_c.tx_valid, bus_c.dout);
        end
        idle(1);
        n_cmp++;
        if ({bus_a.tx_valid, bus_a.dout} !== {1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL basic_a_hold: got tx=%b dout=%h want 0/a5", bus_a.tx_valid, bus_a.dout);
        end
        n_cmp++;
        if ({bus_b.tx_valid, bus_b.dout} !== {1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL basic_b_lat2: got tx=%b dout=%h want 1/a5", bus_b.tx_valid, bus_b.dout);
        end
        idle(1);
        n_cmp++;
        if ({bus_b.tx_valid, bus_b.dout} !== {1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL basic_b_hold: got tx=%b dout=%h want 0/a5", bus_b.tx_valid, bus_b.dout);
        end
    endtask

    // Write burst 0xFE,0xFF,0x00 then three back-to-back reads from 0xFE.
    // Build c (depth 200): 0xFE is out of range, so the burst lands at 0 and 1 instead.
    task automatic test_burst;
        logic [7:0] exp_a [3];
        logic [7:0] exp_c [3];
        exp_a = '{8'h11, 8'h22, 8'h33};
        exp_c = '{8'h00, 8'h22, 8'h33};
        send(2'b00, 8'hFE);
        send(2'b01, 8'h11);
        send(2'b01, 8'h22);
        send(2'b01, 8'h33);
        send(2'b10, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            send(2'b11, 8'h5C);
            n_cmp++;
            if ({bus_a.tx_valid, bus_a.dout} !== {1'b1, exp_a[i]}) begin
                n_err++;
                $display("FAIL burst_a[%0d]: got tx=%b dout=%h want 1/%h",
                         i, bus_a.tx_valid, bus_a.dout, exp_a[i]);
            end
            n_cmp++;
            if ({bus_c.tx_valid, bus_c.dout} !== {1'b1, exp_c[i]}) begin
                n_err++;
                $display("FAIL burst_c[%0d]: got tx=%b dout=%h want 1/%h",
                         i, bus_c.tx_valid, bus_c.dout, exp_c[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if ({bus_b.tx_valid, bus_b.dout} !== {1'b1, exp_a[i-1]}) begin
                    n_err++;
                    $display("FAIL burst_b[%0d]: got tx=%b dout=%h want 1/%h",
                             i - 1, bus_b.tx_valid, bus_b.dout, exp_a[i-1]);
                end
            end
        end
        idle(1);
        n_cmp++;
        if ({bus_a.tx_valid, bus_b.tx_valid, bus_b.dout} !== {1'b0, 1'b1, 8'h33}) begin
            n_err++;
            $display("FAIL burst_tail: got a.tx=%b b.tx=%b b.dout=%h want 0/1/33",
                     bus_a.tx_valid, bus_b.tx_valid, bus_b.dout);
        end
        n_cmp++;
        if ({bus_a.err, bus_b.err, bus_c.err} !== 3'b001) begin
            n_err++;
            $display("FAIL burst_err: got a=%b b=%b c=%b want 0/0/1", bus_a.err, bus_b.err, bus_c.err);
        end
        // rd_addr wrapped to 1 after the burst: put a marker there and read without setting it.
        send(2'b00, 8'h01);
        send(2'b01, 8'h44);
        send(2'b11, 8'h00);
        n_cmp++;
        if (bus_a.dout !== 8'h44) begin
            n_err++;
            $display("FAIL burst_rd_addr_a: got dout=%h want 44", bus_a.dout);
        end
        idle(1);
        n_cmp++;
        if (bus_b.dout !== 8'h44) begin
            n_err++;
            $display("FAIL burst_rd_addr_b: got dout=%h want 44", bus_b.dout);
        end
        // Wrapped write landed at address 0.
        send(2'b10, 8'h00);
        send(2'b11, 8'h00);
        n_cmp++;
        if ({bus_a.dout, bus_c.dout} !== {8'h33, 8'h22}) begin
            n_err++;
            $display("FAIL burst_mem0: got a=%h c=%h want 33/22", bus_a.dout, bus_c.dout);
        end
        idle(1);
    endtask

    task automatic test_out_of_range;
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        n_cmp++;
        if (bus_c.err !== 1'b0) begin
            n_err++;
            $display("FAIL oor_err_cleared: got err=%b want 0", bus_c.err);
        end
        send(2'b11, 8'h00);
        n_cmp++;
        if (bus_c.dout !== 8'h22) begin
            n_err++;
            $display("FAIL oor_retained: got dout=%h want 22", bus_c.dout);
        end
        send(2'b00, 8'hC8);
        send(2'b01, 8'h55);
        n_cmp++;
        if ({bus_a.err, bus_c.err} !== 2'b01) begin
            n_err++;
            $display("FAIL oor_write_err: got a=%b c=%b want 0/1", bus_a.err, bus_c.err);
        end
        send(2'b10, 8'hC8);
        send(2'b11, 8'h00);
        n_cmp++;
        if ({bus_c.tx_valid, bus_c.err, bus_c.dout} !== {1'b1, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL oor_read_c: got tx=%b err=%b dout=%h want 1/1/00",
                     bus_c.tx_valid, bus_c.err, bus_c.dout);
        end
        n_cmp++;
        if ({bus_a.tx_valid, bus_a.err, bus_a.dout} !== {1'b1, 1'b0, 8'h55}) begin
            n_err++;
            $display("FAIL oor_read_a: got tx=%b err=%b dout=%h want 1/0/55",
                     bus_a.tx_valid, bus_a.err, bus_a.dout);
        end
        // Dropped write wrapped wr_addr to 0 but must not have touched mem[0].
        send(2'b10, 8'h00);
        send(2'b11, 8'h00);
        n_cmp++;
        if ({bus_c.dout, bus_c.err} !== {8'h22, 1'b1}) begin
            n_err++;
            $display("FAIL oor_no_write: got dout=%h err=%b want 22/1", bus_c.dout, bus_c.err);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_read;
        rx_valid = 1'b1;
        din      = {2'b11, 8'h00};
        @(negedge clk);
        rx_valid = 1'b0;
        din      = '0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({bus_b.tx_valid, bus_b.err, bus_b.dout} !== 10'h000) begin
            n_err++;
            $display("FAIL midrst_b: got tx=%b err=%b dout=%h want 0/0/00",
                     bus_b.tx_valid, bus_b.err, bus_b.dout);
        end
        n_cmp++;
        if (bus_c.err !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_c_err: got err=%b want 0", bus_c.err);
        end
        idle(1);
        n_cmp++;
        if (bus_b.tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_b_late: got tx=%b want 0", bus_b.tx_valid);
        end
        // rd_addr back at 0, data retained.
        send(2'b11, 8'h00);
        idle(1);
        n_cmp++;
        if ({bus_b.tx_valid, bus_b.dout} !== {1'b1, 8'h33}) begin
            n_err++;
            $display("FAIL midrst_rd0_b: got tx=%b dout=%h want 1/33", bus_b.tx_valid, bus_b.dout);
        end
        // wr_addr back at 0.
        send(2'b01, 8'h77);
        send(2'b10, 8'h00);
        send(2'b11, 8'h00);
        n_cmp++;
        if ({bus_a.dout, bus_c.dout} !== {8'h77, 8'h77}) begin
            n_err++;
            $display("FAIL midrst_wr0: got a=%h c=%h want 77/77", bus_a.dout, bus_c.dout);
        end
        idle(1);
    endtask

    task automatic test_idle_gaps;
        send(2'b00, 8'h20);
        send(2'b10, 8'h20);
        send(2'b01, 8'h5A);
        send(2'b11, 8'h00);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            din = 10'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({bus_a.tx_valid, bus_b.tx_valid, bus_a.dout, bus_b.dout}
                    !== {1'b0, 1'b0, 8'h5A, 8'h5A}) begin
                n_err++;
                $display("FAIL idle[%0d]: got a=%b/%h b=%b/%h want 0/5a 0/5a",
                         i, bus_a.tx_valid, bus_a.dout, bus_b.tx_valid, bus_b.dout);
            end
        end
        din = '0;
        // Both addresses should still be 0x21.
        send(2'b01, 8'h6B);
        send(2'b11, 8'h00);
        n_cmp++;
        if ({bus_a.dout, bus_a.err} !== {8'h6B, 1'b0}) begin
            n_err++;
            $display("FAIL idle_addrs: got dout=%h err=%b want 6b/0", bus_a.dout, bus_a.err);
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        send(2'b00, 8'h30);
        send(2'b10, 8'h30);
        send(2'b01, 8'hC3);
        send(2'b11, 8'h00);
        n_cmp++;
        if ({bus_a.tx_valid, bus_a.dout, bus_c.dout} !== {1'b1, 8'hC3, 8'hC3}) begin
            n_err++;
            $display("FAIL wr_then_rd: got a=%b/%h c=%h want 1/c3 c3",
                     bus_a.tx_valid, bus_a.dout, bus_c.dout);
        end
        idle(1);
        n_cmp++;
        if ({bus_b.tx_valid, bus_b.dout} !== {1'b1, 8'hC3}) begin
            n_err++;
            $display("FAIL wr_then_rd_b: got tx=%b dout=%h want 1/c3", bus_b.tx_valid, bus_b.dout);
        end
        idle(1);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_burst();
        test_out_of_range();
        test_reset_mid_read();
        test_idle_gaps();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_burst_ram.md
Name: spi_burst_ram

Overview:
- Parametrised SPI-slave-side RAM. Successor to the fixed 8-bit/256-deep command RAM.
- Decodes 2-bit command plus DATA_W-bit payload words from the SPI slave (rx_valid/din).
- Returns read data to the SPI slave (tx_valid/dout).
- Adds configurable width/depth, address auto-increment bursts, selectable read latency and an out-of-range error flag.

Parameters:
- DATA_W, 8, payload and memory word width (ADDR_W ≤ DATA_W required).
- ADDR_W, 8, address register width.
- MEM_DEPTH, 256, number of words (1 ≤ MEM_DEPTH ≤ 2^ADDR_W).
- AUTO_INC, 1, 1 = write/read address post-increments after each data/read command.
- READ_LAT, 1, cycles from accepted read command to tx_valid (legal: 1 or 2).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- rx_valid  input  1  din qualifier; one command per cycle when high
- din  input  DATA_W+2  [DATA_W+1:DATA_W] = cmd, [DATA_W-1:0] = payload
- dout  output  DATA_W  read data, held until next read completes
- tx_valid  output  1  one-cycle pulse, dout valid
- err  output  1  sticky out-of-range flag

Behaviour:
- Reset (rst_n low at clk edge) sets dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0, and flushes the read pipeline. Memory contents are not reset; power-up contents are 0.
- Reset mid-read: the pending read is dropped and no tx_valid is produced.
- rx_valid low: no state change. tx_valid still follows pipeline timing.
- cmd 00, set write address: wr_addr <= payload[ADDR_W-1:0].
- cmd 01, write data:
  - If wr_addr < MEM_DEPTH: mem[wr_addr] <= payload. Otherwise the write is dropped and err <= 1.
  - If AUTO_INC: wr_addr <= (wr_addr == MEM_DEPTH-1) ? 0 : wr_addr+1. Out-of-range wr_addr also wraps to 0.
- cmd 10, set read address: rd_addr <= payload[ADDR_W-1:0].
- cmd 11, read:
  - rd_addr < MEM_DEPTH: data = mem[rd_addr]. Otherwise data = 0 and err <= 1.
  - AUTO_INC applies to rd_addr with the same wrap rule; payload is ignored.
  - READ_LAT=1: dout/tx_valid update at the edge that accepts the command.
  - READ_LAT=2: one extra register stage; dout/tx_valid appear one edge later.
- tx_valid is high exactly one cycle per accepted read. Back-to-back reads give back-to-back pulses (full throughput at either latency).
- Write-then-read of the same address on consecutive cycles returns the new data: the write commits at the edge ending cycle t, and the read at t+1 sees it.
- Write and read address registers are independent; cmd 00/01 never disturb rd_addr and vice versa.
- Payload bits above ADDR_W are ignored for address commands.
- err stays set until reset.

Test Plan:
- Basic: cmd00 addr 0x10, cmd01 0xA5, cmd10 0x10, cmd11 (DATA_W=8, READ_LAT=1) -> tx_valid one pulse at the cmd11 accept edge, dout=0xA5, err=0.
- Burst with wrap: AUTO_INC=1, MEM_DEPTH=256. cmd00 0xFE, then cmd01 0x11, 0x22, 0x33 consecutively. cmd10 0xFE, then three cmd11 -> three consecutive tx_valid pulses with dout 0x11, 0x22, 0x33. mem[0]=0x33 and rd_addr ends at 1.
- Latency 2: READ_LAT=2, same sequence as Basic -> tx_valid exactly one edge later than the READ_LAT=1 build. Back-to-back reads produce no gaps.
- Out of range: MEM_DEPTH=200. cmd00 0xC8, cmd01 0x55 -> no memory change, err=1. cmd10 0xC8, cmd11 -> dout=0, tx_valid pulse, err stays 1.
- Reset mid-operation: READ_LAT=2, cmd11 accepted, rst_n low on the next edge -> no tx_valid, dout=0, err=0, both addresses 0, earlier written data retained.
- Idle gaps: rx_valid low between commands, with din toggling random values -> no address, memory or output change.
